vga_timing_detect: RTL and testbench
====================================

Name: vga_timing_detect

Overview:
- Receiving end of the VGA timing interface: consumes a raw hsync/vsync/hblnk/vblnk stream from an internal generator or external source.
- Recovers pixel/line counters, measures the frame geometry and reports lock.
- Sits in front of drawing/capture logic that must align to a timing source it does not own.
- All sync/blank inputs are active-high, as the team's timing generator drives them.

Parameters:
- CNT_W, 11, width of all counters and measurement outputs.
- LOCK_FRAMES, 2, consecutive identical frames required to enter LOCKED (1..15).
- LINE_TIMEOUT, 2047, cycles without a line start before forcing SEARCH.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- hblnk_in  in  1  horizontal blank
- vblnk_in  in  1  vertical blank
- hcount  out  CNT_W  recovered pixel index in line
- vcount  out  CNT_W  recovered line index in frame
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed 1 cycle, aligned with hcount/vcount
- h_total, h_active  out  CNT_W  measured clocks per line / active pixels per line
- v_total, v_active  out  CNT_W  measured lines per frame / active lines per frame
- locked  out  1  geometry stable
- err  out  1  one-cycle pulse on loss of lock or timeout

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All inputs are sampled on posedge `clk`. The block keeps 1-cycle history registers of hblnk_in, vblnk_in and hsync_in.
- Reset: all outputs 0, FSM in SEARCH, history registers 0.
- Line start (LS): hblnk history=1 and hblnk_in=0 in the current sample.
- Frame start (FS): LS while vblnk history=1 and vblnk_in=0.
- Counters, 1-cycle latency:
  - On LS, hcount<=0 on the next edge; otherwise hcount increments, saturating at 2^CNT_W-1.
  - On FS, vcount<=0. On LS without FS, vcount increments, saturating.
  - hcount/vcount free-run in every FSM state. Pass-through sync/blank outputs stay aligned to them.
- Measurement (working registers; published outputs change only as stated below):
  - Line length = hcount+1 at the cycle before LS.
  - Active width = hcount value at which hblnk_in rises.
  - Frame lines = vcount+1 at FS.
  - Active lines = vcount at the first LS with vblnk_in=1.
- FSM states: SEARCH, MEASURE, VERIFY, LOCKED.
  - SEARCH: wait for FS, then go to MEASURE.
  - MEASURE: capture line length from the first full line, plus the frame's other three quantities. At the next FS, latch all four into h_total/h_active/v_total/v_active and go to VERIFY with match count 0.
  - VERIFY: every full line must equal h_total. At each FS, compare the frame quantities with the published outputs.
    - All equal: match count+1; at LOCK_FRAMES go to LOCKED and set locked=1.
    - Any difference: republish the new values and reset match count to 0. Stay in VERIFY; no err.
  - LOCKED: any line length or frame quantity mismatch causes err=1 for one cycle, locked=0, and a return to SEARCH. Published measurements hold their last values.
- Timeout: LINE_TIMEOUT cycles since the last LS, in any state except SEARCH, causes SEARCH. err pulses only if the FSM was in LOCKED.
- Simultaneous events: FS implies LS, and the FS handling takes priority. Timeout and mismatch in the same cycle produce a single err pulse.
- Reset mid-frame: everything returns to reset values on the next edge; the FSM reacquires from the next FS.

Optional Feature:
- Macro: VGA_TIMING_DETECT_SYNC_MEAS_EN.
- When defined, four extra outputs are present, all CNT_W wide: hs_start, hs_width, vs_start, vs_width.
  - hs_start is the hcount at which hsync_in rises; hs_width is the cycle count hsync_in is high.
  - vs_start is the vcount of the first line with vsync_in=1; vs_width is the number of lines with vsync_in high.
  - These are published alongside the other measurements at FS and included in the VERIFY/LOCKED comparison.
- When undefined, these ports and their logic are absent, and lock depends only on the four base measurements.

Test Plan:
- Reset, then drive 800x600 timing from the team generator (1056x628, hblnk high pixels 800..1055, vblnk high lines 600..627) -> after 1+1+LOCK_FRAMES frames: locked=1, h_total=1056, h_active=800, v_total=628, v_active=600; err never asserted.
- Locked, compare outputs against the generator delayed 1 cycle -> hcount/vcount/sync/blank identical every cycle, including the 1055->0 and 627->0 wraps.
- Locked, shorten one line to 1055 clocks -> err pulse of exactly 1 cycle, locked=0, state SEARCH; relock after LOCK_FRAMES+2 frames.
- Locked, hold hblnk_in=1 for 2100 cycles -> err pulse at LINE_TIMEOUT cycles after the last LS; locked=0.
- Change geometry to 640x480 (800x525) during VERIFY -> outputs republished to 800/640/525/480, match count restarted, no err, locked after LOCK_FRAMES further frames.
- With VGA_TIMING_DETECT_SYNC_MEAS_EN and 800x600 stimulus -> hs_start=840, hs_width=128, vs_start=601, vs_width=4.

Source files
------------

// File: rtl/vga_timing_detect_if.sv
// vga_timing_detect_if: raw active-high sync/blank stream from a timing source to a detector
interface vga_timing_detect_if;
  logic hsync_in;
  logic vsync_in;
  logic hblnk_in;
  logic vblnk_in;
  modport master (output hsync_in, vsync_in, hblnk_in, vblnk_in);
  modport slave (input hsync_in, vsync_in, hblnk_in, vblnk_in);
endinterface

// File: rtl/vga_timing_detect.sv
// vga_timing_detect: recovers pixel/line counters, measures frame geometry and reports lock; VGA_TIMING_DETECT_SYNC_MEAS_EN adds sync position/width measurements
module vga_timing_detect #(
  parameter int CNT_W = 11,
  parameter int LOCK_FRAMES = 2,
  parameter int LINE_TIMEOUT = 2047
) (
  input  logic clk,
  input  logic rst,
  vga_timing_detect_if.slave tim_i,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic hsync_out,
  output logic vsync_out,
  output logic hblnk_out,
  output logic vblnk_out,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
  output logic [CNT_W-1:0] hs_start,
  output logic [CNT_W-1:0] hs_width,
  output logic [CNT_W-1:0] vs_start,
  output logic [CNT_W-1:0] vs_width,
`endif
  output logic locked,
  output logic err
);
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
  localparam int NM = 8;
`else
  localparam int NM = 4;
`endif
  localparam int TW = $clog2(LINE_TIMEOUT + 1);
  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
  state_t state_q, state_d;
  logic hblnk_q, vblnk_q, hsync_q, vsync_q, v_seen_q;
  logic [CNT_W-1:0] hcount_q, hcount_d, vcount_q, vcount_d, len_now, h_act_q, v_act_q;
  logic [TW-1:0] tcnt_q;
  logic [3:0] match_q, match_d;
  logic bad_q, bad_d, err_q, err_d, publish;
  logic [NM*CNT_W-1:0] pub_q, meas_now;
  logic ls, fs, timeout, line_bad, frame_bad;

  assign ls = hblnk_q & ~tim_i.hblnk_in;
  assign fs = ls & vblnk_q & ~tim_i.vblnk_in;
  assign hcount_d = ls ? '0 : hcount_q + CNT_W'(~&hcount_q);
  assign vcount_d = fs ? '0 : vcount_q + CNT_W'(ls & ~&vcount_q);
  assign len_now = hcount_q + CNT_W'(1);
  assign timeout = (state_q != SEARCH) & (tcnt_q == TW'(LINE_TIMEOUT)) & ~ls;
  assign line_bad = ls & (len_now != h_total);
  assign frame_bad = fs & (meas_now != pub_q);
  assign {h_total, h_active, v_total, v_active} = pub_q[NM*CNT_W-1 -: 4*CNT_W];
  assign {hcount, vcount} = {hcount_q, vcount_q};
  assign {hsync_out, vsync_out, hblnk_out, vblnk_out} = {hsync_q, vsync_q, hblnk_q, vblnk_q};
  assign locked = state_q == LOCKED;
  assign err = err_q;

`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
  logic [CNT_W-1:0] hs_st_q, hs_wd_q, vs_st_q, vs_wd_q;
  assign meas_now = {len_now, h_act_q, vcount_q + CNT_W'(1), v_act_q, hs_st_q, hs_wd_q, vs_st_q, vs_wd_q};
  assign {hs_start, hs_width, vs_start, vs_width} = pub_q[4*CNT_W-1:0];
  // sync edges mark positions; widths are the distance from the rising edge to the falling edge
  always_ff @(posedge clk)
    if (rst) begin
      {hs_st_q, hs_wd_q, vs_st_q, vs_wd_q} <= '0;
    end else begin
      if (tim_i.hsync_in & ~hsync_q) hs_st_q <= hcount_d;
      if (~tim_i.hsync_in & hsync_q) hs_wd_q <= hcount_d - hs_st_q;
      if (tim_i.vsync_in & ~vsync_q) vs_st_q <= vcount_d;
      if (~tim_i.vsync_in & vsync_q) vs_wd_q <= vcount_d - vs_st_q;
    end
`else
  assign meas_now = {len_now, h_act_q, vcount_q + CNT_W'(1), v_act_q};
`endif

  // history, free-running counters, working measurements and published results
  always_ff @(posedge clk)
    if (rst) begin
      {hblnk_q, vblnk_q, hsync_q, vsync_q, v_seen_q, bad_q, err_q} <= '0;
      {hcount_q, vcount_q, h_act_q, v_act_q} <= '0;
      tcnt_q <= '0;
      match_q <= '0;
      pub_q <= '0;
    end else begin
      {hblnk_q, vblnk_q, hsync_q, vsync_q} <= {tim_i.hblnk_in, tim_i.vblnk_in, tim_i.hsync_in, tim_i.vsync_in};
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      tcnt_q <= ls ? TW'(1) : tcnt_q + TW'(tcnt_q != TW'(LINE_TIMEOUT));
      if (tim_i.hblnk_in & ~hblnk_q) h_act_q <= hcount_d;
      if (ls & tim_i.vblnk_in & ~v_seen_q) v_act_q <= vcount_d;
      v_seen_q <= ~fs & (v_seen_q | (ls & tim_i.vblnk_in));
      match_q <= match_d;
      bad_q <= bad_d;
      err_q <= err_d;
      if (publish) pub_q <= meas_now;
    end

  // state register
  always_ff @(posedge clk) state_q <= rst ? SEARCH : state_d;

  // acquisition sequence: frame boundaries advance it, timeouts and mismatches drop it
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  state_d = fs ? MEASURE : SEARCH;
      MEASURE: state_d = timeout ? SEARCH : fs ? VERIFY : MEASURE;
      VERIFY:  state_d = timeout ? SEARCH : (fs & ~frame_bad & ~bad_q & (match_q + 4'd1 == 4'(LOCK_FRAMES))) ? LOCKED : VERIFY;
      LOCKED:  state_d = (timeout | line_bad | frame_bad) ? SEARCH : LOCKED;
      default: state_d = SEARCH;
    endcase
  end

  // publishing, match counting, bad-line memory for the frame and the error pulse
  always_comb begin
    publish = fs & ((state_q == MEASURE) | ((state_q == VERIFY) & (frame_bad | bad_q)));
    match_d = publish ? '0 : (fs & (state_q == VERIFY)) ? match_q + 4'd1 : match_q;
    bad_d = ~fs & (bad_q | ((state_q == VERIFY) & line_bad));
    err_d = (state_q == LOCKED) & (timeout | line_bad | frame_bad);
  end
endmodule

// File: tb/tb_vga_timing_detect.sv
// tb_vga_timing_detect: randomized timing stream checked every cycle against a behavioural model
module tb_vga_timing_detect;
  localparam int CW = 11, LF = 2, LT = 100;
  localparam int MAXC = (1 << CW) - 1;
  localparam int S_SEARCH = 0, S_MEASURE = 1, S_VERIFY = 2, S_LOCKED = 3;
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
  localparam int NM = 8;
`else
  localparam int NM = 4;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_detect_if tif();
  logic [CW-1:0] hcount, vcount, h_total, h_active, v_total, v_active;
  logic hsync_out, vsync_out, hblnk_out, vblnk_out, locked, err;
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
  logic [CW-1:0] hs_start, hs_width, vs_start, vs_width;
`endif

  vga_timing_detect #(.CNT_W(CW), .LOCK_FRAMES(LF), .LINE_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .tim_i(tif),
    .hcount(hcount), .vcount(vcount),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
    .hs_start(hs_start), .hs_width(hs_width), .vs_start(vs_start), .vs_width(vs_width),
`endif
    .locked(locked), .err(err));

  int checks = 0, errors = 0, err_hi = 0;
  // generator: geometry {htot, hact, hs_start, hs_width, vtot, vact, vs_start, vs_width}
  int geo[8], pend[8];
  bit pend_v = 0, stall_arm = 0, gchk = 0;
  int gx = 0, gy = 0, dgx = 0, dgy = 0, short_y = -1, stall_x = 0, stall_n = 0;
  // model
  int t = 0, t_ls = 0, ln = 0, st = S_SEARCH, match = 0;
  int pub[8], wk[8];
  bit phb, pvb, phs, pvs, vseen, bad, e_err;

  function automatic int mmin(int a, int b);
    return a < b ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic gen_drive();
    tif.hblnk_in = gx >= geo[1];
    tif.vblnk_in = gy >= geo[5];
    tif.hsync_in = gx >= geo[2] && gx < geo[2] + geo[3];
    tif.vsync_in = gy >= geo[6] && gy < geo[6] + geo[7];
    dgx = gx;
    dgy = gy;
  endtask

  task automatic gen_advance();
    if (stall_n > 0) begin
      stall_n--;
      return;
    end
    if (stall_arm && gx == stall_x) begin
      stall_arm = 0;
      stall_n = 120;
      return;
    end
    gx++;
    if (gx >= geo[0] - int'(gy == short_y)) begin
      gx = 0;
      if (gy == short_y) short_y = -1;
      gy++;
      if (gy >= geo[4]) begin
        gy = 0;
        if (pend_v) begin
          geo = pend;
          pend_v = 0;
        end
      end
    end
  endtask

  // one sampled input set: detection events, frame bookkeeping and acquisition rules
  task automatic model_step(input bit r, input bit hb, input bit vb, input bit hs, input bit vs);
    bit ls, fs, lbad, fbad, tout;
    int len, hd;
    int cur[8];
    t++;
    if (r) begin
      t_ls = t; ln = 0; st = S_SEARCH; match = 0;
      {phb, pvb, phs, pvs, vseen, bad, e_err} = '0;
      pub = '{default: 0};
      wk = '{default: 0};
      return;
    end
    ls = phb && !hb;
    fs = ls && pvb && !vb;
    len = t - t_ls;
    cur = wk;
    cur[0] = len;
    cur[2] = ln + 1;
    for (int i = 0; i < 8; i++) cur[i] = cur[i] & MAXC;
    tout = st != S_SEARCH && len >= LT && !ls;
    lbad = ls && (len & MAXC) != pub[0];
    fbad = 0;
    for (int i = 0; i < NM; i++) if (fs && cur[i] != pub[i]) fbad = 1;
    e_err = 0;
    case (st)
      S_SEARCH: if (fs) st = S_MEASURE;
      S_MEASURE: if (tout) st = S_SEARCH; else if (fs) begin pub = cur; match = 0; st = S_VERIFY; end
      S_VERIFY:
        if (tout) st = S_SEARCH;
        else if (fs) begin
          if (fbad || bad) begin pub = cur; match = 0; end
          else begin match++; if (match == LF) st = S_LOCKED; end
        end else if (lbad) bad = 1;
      default: if (tout || lbad || fbad) begin e_err = 1; st = S_SEARCH; end
    endcase
    if (fs) bad = 0;
    if (hb && !phb) wk[1] = mmin(len, MAXC);
    hd = ls ? 0 : mmin(len, MAXC);
    if (ls) begin
      t_ls = t;
      ln = fs ? 0 : mmin(ln + 1, MAXC);
      if (vb && !vseen) wk[3] = ln;
      vseen = !fs && (vseen || vb);
    end
    if (hs && !phs) wk[4] = hd;
    if (!hs && phs) wk[5] = (hd - wk[4]) & MAXC;
    if (vs && !pvs) wk[6] = ln;
    if (!vs && pvs) wk[7] = (ln - wk[6]) & MAXC;
    {phb, pvb, phs, pvs} = {hb, vb, hs, vs};
  endtask

  task automatic compare();
    chk("hcount", int'(hcount), mmin(t - t_ls, MAXC));
    chk("vcount", int'(vcount), ln);
    chk("hsync_out", int'(hsync_out), int'(phs));
    chk("vsync_out", int'(vsync_out), int'(pvs));
    chk("hblnk_out", int'(hblnk_out), int'(phb));
    chk("vblnk_out", int'(vblnk_out), int'(pvb));
    chk("h_total", int'(h_total), pub[0]);
    chk("h_active", int'(h_active), pub[1]);
    chk("v_total", int'(v_total), pub[2]);
    chk("v_active", int'(v_active), pub[3]);
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
    chk("hs_start", int'(hs_start), pub[4]);
    chk("hs_width", int'(hs_width), pub[5]);
    chk("vs_start", int'(vs_start), pub[6]);
    chk("vs_width", int'(vs_width), pub[7]);
`endif
    chk("locked", int'(locked), int'(st == S_LOCKED));
    chk("err", int'(err), int'(e_err));
    if (err) err_hi++;
    if (gchk) begin
      chk("gen_hcount", int'(hcount), dgx);
      chk("gen_vcount", int'(vcount), dgy);
    end
  endtask

  task automatic cycle();
    gen_drive();
    @(posedge clk);
    model_step(rst, tif.hblnk_in, tif.vblnk_in, tif.hsync_in, tif.vsync_in);
    gen_advance();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic geo_lit(input string nm, input int ht, input int ha, input int vt, input int va);
    chk({nm, "_h_total"}, int'(h_total), ht);
    chk({nm, "_h_active"}, int'(h_active), ha);
    chk({nm, "_v_total"}, int'(v_total), vt);
    chk({nm, "_v_active"}, int'(v_active), va);
  endtask

  initial begin
    int e0, k;
    geo = '{40, 32, 34, 4, 12, 10, 10, 1};
    pub = '{default: 0};
    wk = '{default: 0};
    run(3);
    rst = 1'b0;
    chk("rst_locked", int'(locked), 0);
    chk("rst_h_total", int'(h_total), 0);
    chk("rst_hcount", int'(hcount), 0);
    run(5 * 480);
    chk("lockA", int'(locked), 1);
    geo_lit("A", 40, 32, 12, 10);
    chk("noerrA", err_hi, 0);
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
    chk("A_hs_start", int'(hs_start), 34);
    chk("A_hs_width", int'(hs_width), 4);
    chk("A_vs_start", int'(vs_start), 10);
    chk("A_vs_width", int'(vs_width), 1);
`endif
    gchk = 1;
    run(2 * 480);
    gchk = 0;
    k = 0;
    while (!(gx == 0 && gy == 0) && k < 1000) begin cycle(); k++; end
    short_y = $urandom_range(1, geo[4] - 2);
    e0 = err_hi;
    run(480);
    chk("short_err_cycles", err_hi - e0, 1);
    chk("short_locked", int'(locked), 0);
    run(5 * 480);
    chk("relock_short", int'(locked), 1);
    stall_x = $urandom_range(geo[1], geo[0] - 1);
    stall_arm = 1;
    e0 = err_hi;
    run(480 + 130);
    chk("stall_err_cycles", err_hi - e0, 1);
    chk("stall_locked", int'(locked), 0);
    k = 0;
    while (st != S_VERIFY && k < 5 * 480) begin cycle(); k++; end
    if (st != S_VERIFY) begin
      errors++;
      $display("FAIL wait_verify got timeout expected VERIFY");
    end
    pend = '{30, 24, 26, 3, 9, 7, 7, 1};
    pend_v = 1;
    e0 = err_hi;
    run(480 + 5 * 270);
    chk("lockB", int'(locked), 1);
    geo_lit("B", 30, 24, 9, 7);
    chk("noerrB", err_hi - e0, 0);
`ifdef VGA_TIMING_DETECT_SYNC_MEAS_EN
    chk("B_hs_start", int'(hs_start), 26);
    chk("B_hs_width", int'(hs_width), 3);
`endif
    run($urandom_range(50, 250));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_h_total", int'(h_total), 0);
    chk("midrst_vcount", int'(vcount), 0);
    run(6 * 270);
    chk("relock_rst", int'(locked), 1);
    geo_lit("R", 30, 24, 9, 7);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
